vec_alu_pipe: RTL

Pipelined, parametrised SIMD vector ALU, the successor to the combinational 256-bit lane ALU. It splits a REG_WIDTH operand pair into NUM_LANES independent ELEM_WIDTH lanes and adds a valid/ready handshake on input and output, two pipeline stages with backpressure, per-lane flags, logical shift right, and an iterative cross-lane reduction-sum op. It sits between the vector register file read ports and the writeback mux of the processing element.

---
 rtl/vec_alu_pkg.sv | 20 ++
 rtl/vec_alu_pipe_if.sv | 28 ++
 rtl/vec_alu_lane.sv | 46 ++++
 rtl/vec_alu_pipe.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/vec_alu_pkg.sv
// Shared opcode encodings and per-lane flag bundle for the pipelined vector ALU.
package vec_alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SRL  = 3'b110;
    localparam logic [2:0] ALU_RSUM = 3'b111;

    typedef struct packed {
        logic ovf;
        logic carry;
        logic zero;
        logic neg;
    } alu_flags_t;

endpackage

// File: rtl/vec_alu_pipe_if.sv
// Operand/result handshake bundle between the register-file read ports and writeback.
interface vec_alu_pipe_if #(
    parameter int REG_WIDTH = 256,
    parameter int NUM_LANES = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [REG_WIDTH-1:0] A;
    logic [REG_WIDTH-1:0] B;
    logic [2:0]           ALUControl;
    logic                 out_valid;
    logic                 out_ready;
    logic [REG_WIDTH-1:0] Result;
    logic [NUM_LANES-1:0] OverFlow;
    logic [NUM_LANES-1:0] Carry;
    logic [NUM_LANES-1:0] Zero;
    logic [NUM_LANES-1:0] Negative;

    modport master (
        output in_valid, A, B, ALUControl, out_ready,
        input  in_ready, out_valid, Result, OverFlow, Carry, Zero, Negative
    );

    modport slave (
        input  in_valid, A, B, ALUControl, out_ready,
        output in_ready, out_valid, Result, OverFlow, Carry, Zero, Negative
    );
endinterface

// File: rtl/vec_alu_lane.sv
// One combinational ALU lane: result plus ovf/carry/zero/neg for every opcode except RSUM.
module vec_alu_lane
    import vec_alu_pkg::*;
#(
    parameter int ELEM_WIDTH = 32
) (
    input  logic [ELEM_WIDTH-1:0] a,
    input  logic [ELEM_WIDTH-1:0] b,
    input  logic [2:0]            op,
    output logic [ELEM_WIDTH-1:0] result,
    output alu_flags_t            flags
);
    localparam int SHW = $clog2(ELEM_WIDTH);
    localparam int MSB = ELEM_WIDTH - 1;

    logic                  is_sub;
    logic                  is_arith;
    logic [ELEM_WIDTH-1:0] b_eff;
    logic [ELEM_WIDTH:0]   sum;
    logic [SHW-1:0]        shamt;

    always_comb begin
        is_sub   = (op == ALU_SUB);
        is_arith = (op == ALU_ADD) || is_sub;
        // SUB is A + ~B + 1, so the carry-out reads as "no borrow"
        b_eff    = is_sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{ELEM_WIDTH{1'b0}}, is_sub};
        shamt    = b[SHW-1:0];

        result = '0;
        case (op)
            ALU_ADD, ALU_SUB: result = sum[ELEM_WIDTH-1:0];
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            ALU_SLL:          result = a << shamt;
            ALU_SLT:          result = {{(ELEM_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SRL:          result = a >> shamt;
            default:          result = '0;
        endcase

        flags.ovf   = is_arith && (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
        flags.carry = is_arith && sum[ELEM_WIDTH];
        flags.zero  = (result == '0);
        flags.neg   = result[MSB];
    end
endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage SIMD vector ALU with valid/ready on both sides and an iterative lane-sum op.
// state    | meaning
// S_IDLE   | S1 empty, ready for a beat
// S_HOLD   | S1 holds a lane-wise op waiting to move into S2
// S_REDUCE | S1 holds RSUM; accumulating lanes, then hands acc to S2
module vec_alu_pipe
    import vec_alu_pkg::*;
#(
    parameter int REG_WIDTH  = 256,
    parameter int ELEM_WIDTH = 32,
    parameter int NUM_LANES  = 8
) (
    input logic           clk,
    input logic           rst,
    vec_alu_pipe_if.slave bus
);
    localparam int CW = $clog2(NUM_LANES + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REDUCE} s1_state_t;

    s1_state_t state, state_nxt;

    logic [REG_WIDTH-1:0]  s1_a, s1_b;
    logic [2:0]            s1_op;
    logic [CW-1:0]         cnt;
    logic [ELEM_WIDTH-1:0] acc;

    logic                  s2_valid;
    logic [REG_WIDTH-1:0]  s2_result;
    logic [NUM_LANES-1:0]  s2_ovf, s2_carry, s2_zero, s2_neg;

    logic                  in_ready, accept, s1_to_s2, s2_free;
    logic [CW-1:0]         lane_sel;
    logic [ELEM_WIDTH-1:0] red_word;

    logic [REG_WIDTH-1:0]  lane_result;
    alu_flags_t            lane_flags [NUM_LANES];
    logic [REG_WIDTH-1:0]  res_nxt;
    logic [NUM_LANES-1:0]  ovf_nxt, carry_nxt, zero_nxt, neg_nxt;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        vec_alu_lane #(.ELEM_WIDTH(ELEM_WIDTH)) u_lane (
            .a      (s1_a[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .b      (s1_b[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .op     (s1_op),
            .result (lane_result[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .flags  (lane_flags[i])
        );
    end

    assign s2_free = !s2_valid || bus.out_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        s1_to_s2  = 1'b0;
        case (state)
            S_IDLE: in_ready = 1'b1;
            S_HOLD: begin
                if (s2_free) begin
                    s1_to_s2 = 1'b1;
                    in_ready = 1'b1;
                end
            end
            // in_ready stays low for the whole reduction, including the hand-off cycle
            S_REDUCE: begin
                if (cnt == '0 && s2_free) s1_to_s2 = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        accept = bus.in_valid && in_ready;
        if (accept) state_nxt = (bus.ALUControl == ALU_RSUM) ? S_REDUCE : S_HOLD;
        else if (s1_to_s2) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // cnt counts lanes still to be added; lane NUM_LANES-cnt is consumed this cycle
    always_comb begin
        lane_sel = CW'(NUM_LANES) - cnt;
        red_word = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (lane_sel == CW'(i)) red_word = s1_a[i*ELEM_WIDTH +: ELEM_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_op <= ALU_ADD;
            cnt   <= '0;
            acc   <= '0;
        end else if (accept) begin
            s1_a  <= bus.A;
            s1_b  <= bus.B;
            s1_op <= bus.ALUControl;
            acc   <= '0;
            cnt   <= (bus.ALUControl == ALU_RSUM) ? CW'(NUM_LANES) : '0;
        end else if (state == S_REDUCE && cnt != '0) begin
            acc <= acc + red_word;
            cnt <= cnt - CW'(1);
        end
    end

    always_comb begin
        res_nxt = lane_result;
        for (int i = 0; i < NUM_LANES; i++) begin
            ovf_nxt[i]   = lane_flags[i].ovf;
            carry_nxt[i] = lane_flags[i].carry;
            zero_nxt[i]  = lane_flags[i].zero;
            neg_nxt[i]   = lane_flags[i].neg;
        end
        if (s1_op == ALU_RSUM) begin
            res_nxt                   = '0;
            res_nxt[ELEM_WIDTH-1:0]   = acc;
            ovf_nxt                   = '0;
            carry_nxt                 = '0;
            zero_nxt                  = '1;
            neg_nxt                   = '0;
            zero_nxt[0]               = (acc == '0);
            neg_nxt[0]                = acc[ELEM_WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_ovf    <= '0;
            s2_carry  <= '0;
            s2_zero   <= '0;
            s2_neg    <= '0;
        end else if (s1_to_s2) begin
            s2_valid  <= 1'b1;
            s2_result <= res_nxt;
            s2_ovf    <= ovf_nxt;
            s2_carry  <= carry_nxt;
            s2_zero   <= zero_nxt;
            s2_neg    <= neg_nxt;
        end else if (bus.out_ready) begin
            s2_valid  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.Result    = s2_result;
    assign bus.OverFlow  = s2_ovf;
    assign bus.Carry     = s2_carry;
    assign bus.Zero      = s2_zero;
    assign bus.Negative  = s2_neg;
endmodule
